// File: rtl/ex_mem_redirect_controller_if.sv
// ex_mem_redirect_controller_if
// Bundles the EX/MEM control fields entering the redirect controller with the
// redirect/flush return path heading back toward the front of the pipeline.
// The master side is the pipeline (EX/MEM register plus IF); the slave side
// is the redirect controller itself.
interface ex_mem_redirect_controller_if #(
  parameter int PC_W = 32
);
  logic            in_valid;
  logic [PC_W-1:0] jump_pc;
  logic            force_jump;
  logic            branch;
  logic [2:0]      func3;
  logic            alu_zero;
  logic            alu_lt;
  logic            alu_ltu;
  logic            redirect_ready;

  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            flush_if_id;
  logic            flush_id_ex;
  logic            flush_ex_mem;
  logic            misalign_err;
  logic [31:0]     redirect_count;
  logic [31:0]     branch_count;

  modport master (
    output in_valid, jump_pc, force_jump, branch, func3,
           alu_zero, alu_lt, alu_ltu, redirect_ready,
    input  redirect_valid, redirect_pc, flush_if_id, flush_id_ex,
           flush_ex_mem, misalign_err, redirect_count, branch_count
  );

  modport slave (
    input  in_valid, jump_pc, force_jump, branch, func3,
           alu_zero, alu_lt, alu_ltu, redirect_ready,
    output redirect_valid, redirect_pc, flush_if_id, flush_id_ex,
           flush_ex_mem, misalign_err, redirect_count, branch_count
  );
endinterface

// File: rtl/ex_mem_redirect_controller.sv
// ex_mem_redirect_controller
// Resolves branches and jumps in MEM and issues a registered PC redirect to IF
// over a valid/ready handshake, squashing IF/ID, ID/EX and EX/MEM until the
// wrong-path instructions have drained.
// Optional statistics counters are built only when REDIRECT_STATS_EN is
// defined; otherwise branch_count/redirect_count are tied to zero.
module ex_mem_redirect_controller #(
  parameter int PC_W          = 32,
  parameter int SHADOW_CYCLES = 2
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  ex_mem_redirect_controller_if.slave   bus
);

  // The shadow counter only ever holds values up to SHADOW_CYCLES-1.
  localparam int CNT_W = (SHADOW_CYCLES > 1) ? $clog2(SHADOW_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SHADOW_LOAD = CNT_W'(SHADOW_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SHADOW = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic             flush_q, flush_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] shadow_cnt_q, shadow_cnt_d;

  logic cond;
  logic taken;
  logic aligned;
  logic handshake;

  // Branch condition selected by func3; 010/011 are never taken.
  always_comb begin
    cond = 1'b0;
    case (bus.func3)
      3'b000:  cond = bus.alu_zero;
      3'b001:  cond = ~bus.alu_zero;
      3'b100:  cond = bus.alu_lt;
      3'b101:  cond = ~bus.alu_lt;
      3'b110:  cond = bus.alu_ltu;
      3'b111:  cond = ~bus.alu_ltu;
      default: cond = 1'b0;
    endcase
  end

  assign taken     = bus.in_valid & (bus.force_jump | (bus.branch & cond));
  assign aligned   = (bus.jump_pc[1:0] == 2'b00);
  assign handshake = redirect_valid_q & bus.redirect_ready;

  // Next-state and output logic: EX/MEM inputs only matter while IDLE, since
  // anything arriving during HOLD or SHADOW is wrong-path.
  always_comb begin
    state_d          = state_q;
    redirect_pc_d    = redirect_pc_q;
    redirect_valid_d = redirect_valid_q;
    flush_d          = flush_q;
    misalign_d       = 1'b0;
    shadow_cnt_d     = shadow_cnt_q;
    case (state_q)
      IDLE: begin
        flush_d = 1'b0;
        if (taken) begin
          if (aligned) begin
            redirect_pc_d    = bus.jump_pc;
            redirect_valid_d = 1'b1;
            flush_d          = 1'b1;
            state_d          = HOLD;
          end else begin
            misalign_d = 1'b1;
          end
        end
      end
      HOLD: begin
        flush_d = 1'b1;
        if (handshake) begin
          redirect_valid_d = 1'b0;
          shadow_cnt_d     = SHADOW_LOAD;
          state_d          = SHADOW;
        end
      end
      SHADOW: begin
        if (shadow_cnt_q == '0) begin
          flush_d = 1'b0;
          state_d = IDLE;
        end else begin
          flush_d      = 1'b1;
          shadow_cnt_d = shadow_cnt_q - 1'b1;
        end
      end
      default: begin
        redirect_valid_d = 1'b0;
        flush_d          = 1'b0;
        state_d          = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any redirect in flight at once.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q          <= IDLE;
      redirect_pc_q    <= '0;
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
      misalign_q       <= 1'b0;
      shadow_cnt_q     <= '0;
    end else begin
      state_q          <= state_d;
      redirect_pc_q    <= redirect_pc_d;
      redirect_valid_q <= redirect_valid_d;
      flush_q          <= flush_d;
      misalign_q       <= misalign_d;
      shadow_cnt_q     <= shadow_cnt_d;
    end
  end

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush_if_id    = flush_q;
  assign bus.flush_id_ex    = flush_q;
  assign bus.flush_ex_mem   = flush_q;
  assign bus.misalign_err   = misalign_q;

`ifdef REDIRECT_STATS_EN
  logic [31:0] branch_count_q, branch_count_d;
  logic [31:0] redirect_count_q, redirect_count_d;

  // Statistics: branches evaluated in IDLE and completed redirect handshakes.
  always_comb begin
    branch_count_d   = branch_count_q;
    redirect_count_d = redirect_count_q;
    if ((state_q == IDLE) && bus.in_valid && bus.branch) begin
      branch_count_d = branch_count_q + 32'd1;
    end
    if (handshake) begin
      redirect_count_d = redirect_count_q + 32'd1;
    end
  end

  // Counter registers, wrapping naturally modulo 2^32.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      branch_count_q   <= '0;
      redirect_count_q <= '0;
    end else begin
      branch_count_q   <= branch_count_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  assign bus.branch_count   = branch_count_q;
  assign bus.redirect_count = redirect_count_q;
`else
  assign bus.branch_count   = 32'd0;
  assign bus.redirect_count = 32'd0;
`endif

endmodule
